isqrt_pipe: RTL
===============

# isqrt_pipe

Parametrised, fully pipelined unsigned/signed integer square root with valid/tag handshake, a global clock enable, optional fractional result bits and an exact remainder output. Accepts one radicand per enabled cycle and retires one root bit per stage. Sits in the math_pipelined library as the generalised successor of the fixed 32-bit sqrt pipeline, for datapaths that need stall support, bubble tracking and exact results.

## Interface
- WIDTH, 32: radicand width in bits; even, ≥4.
- FRAC_OUT, 0: fractional bits in the root; 0..WIDTH/2.
- SIGNED, 0: 1 = treat x as two's complement and flag negatives.
- TAG_W, 8: width of the sideband tag carried alongside each sample.
- Derived: RW = WIDTH/2 + FRAC_OUT (root width, pipeline depth); RMW = RW+1 (remainder width).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ce  in  1  pipeline enable; 0 freezes every stage.
- in_valid  in  1  x/in_tag are sampled on a clk edge with ce=1 and in_valid=1.
- x  in  WIDTH  radicand, an integer.
- in_tag  in  TAG_W  sideband, returned unchanged with the result.
- out_valid  out  1  result on root/rem/err/out_tag is valid.
- root  out  RW  floor(sqrt(x·2^(2·FRAC_OUT))), i.e. a UQ(WIDTH/2).(FRAC_OUT) value.
- rem  out  RMW  x·2^(2·FRAC_OUT) − root², range 0..2·root.
- err  out  1  SIGNED=1 and x was negative.
- out_tag  out  TAG_W  tag of the sample being presented.

## Operation
- Stage registers s[0..RW], each holding valid, tag, err, partial remainder (RMW+1 bits, signed trial), partial root (RW bits) and the unconsumed radicand bits (WIDTH+2·FRAC_OUT).
- s[0] captures: R = x_abs << 2·FRAC_OUT, rem = 0, root = 0, valid = in_valid, tag, err. For SIGNED=1 and x[WIDTH-1]=1: err=1, R forced to 0.
- Stage i (1..RW), non-restoring-free digit recurrence: bring down the top two unconsumed bits: t = (rem<<2 | bits) − (root<<2 | 1). If t ≥ 0: rem = t, root = root<<1 | 1; else rem = rem<<2 | bits, root = root<<1.
- All arithmetic unsigned except the trial sign test; no truncation: rem never exceeds RMW bits.
- Outputs are driven from s[RW]. When s[RW].valid=0, root, rem, err and out_tag are forced to 0.
- Invalid slots (bubbles) travel through the pipe; their data is don't-care internally but never visible.
- ce=0: every stage, including valid bits, holds; in_valid and x are ignored that cycle; outputs hold.
- No backpressure output: the producer owns ce; the block never drops a sample while ce=1.

## Timing
- Reset (rst_n=0, asynchronous): all valid bits, out_valid, root, rem, err and out_tag go to 0 immediately; all in-flight samples are discarded. The first sample is accepted on the first edge with rst_n=1, ce=1, in_valid=1.
- Latency: a sample taken at edge n appears on outputs after edge n+RW, counting only edges with ce=1. Default (WIDTH=32, FRAC_OUT=0): 16 enabled edges.
- Throughput: one result per enabled cycle; back-to-back samples emerge back-to-back in order.
- Stall mid-flight: latency in wall-clock cycles extends by the number of ce=0 cycles; no sample is duplicated or lost.
- Reset asserted while ce=0 still clears everything.
- Boundaries: x=0 → root 0, rem 0. x = all ones (SIGNED=0) → root = 2^(WIDTH/2)−1, rem = 2·root. Most-negative x (SIGNED=1) → err=1, root=0, rem=0.

## Test plan
- WIDTH=32, FRAC_OUT=0, ce=1: x=0, 1, 1000000, 0xFFFFFFFF back-to-back → out_valid on 4 consecutive cycles, 16 edges later; root/rem = 0/0, 1/0, 1000/0, 0xFFFF/0x1FFFE, tags in order.
- FRAC_OUT=8: x=2 → root=362 (0x16A), rem=28. x=4 → root=512, rem=0.
- SIGNED=1: x=0xFFFFFFFC, tag 0x5A → err=1, root=0, rem=0, out_tag=0x5A; following x=9 → root 3, rem 0, err 0.
- Stall: send 3 samples, drop ce for 5 cycles at the 4th edge → outputs and out_valid frozen for those cycles; all 3 results later appear with correct values, each arriving 21 cycles after it was sampled.
- Bubbles + reset: alternate in_valid 1/0 and check out_valid alternates. Pull rst_n low mid-stream → out_valid=0 and outputs=0 before the next edge; no pre-reset results appear afterwards.
- Random: 10^5 random x for WIDTH∈{8,32}, FRAC_OUT∈{0,3}, random ce/in_valid → root² ≤ R < (root+1)², rem = R−root², order and tags preserved.

Source files
------------

// File: rtl/isqrt_pipe.sv
// -----------------------------------------------------------------------------
// isqrt_pipe
//   Fully pipelined integer square root. One radicand enters per enabled
//   cycle and one root bit is retired per stage. The design produces an
//   exact remainder and, optionally, fractional root bits.
//
//   The root is floor(sqrt(x * 4^FRAC_OUT)). The remainder is
//   x * 4^FRAC_OUT - root^2.
//
// Parameters
//   WIDTH    : radicand width. Must be even and at least 4.
//   FRAC_OUT : number of fractional root bits, 0..WIDTH/2.
//   SIGNED   : 1 = x is two's complement; negative inputs raise err.
//   TAG_W    : width of the sideband tag.
//   RW       : root width, which is also the pipeline depth.
//   RMW      : remainder width.
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset; clears every valid bit
//   ce        : pipeline enable; 0 freezes every stage
//   in_valid  : x/in_tag are sampled when ce=1 and in_valid=1
//   x         : radicand
//   in_tag    : sideband returned with the result
//   out_valid : root/rem/err/out_tag carry a result
//   root      : integer square root, UQ(WIDTH/2).(FRAC_OUT)
//   rem       : exact remainder, 0..2*root
//   err       : the radicand was negative (SIGNED=1 only)
//   out_tag   : tag of the presented result
// -----------------------------------------------------------------------------
module isqrt_pipe #(
  parameter int WIDTH    = 32,
  parameter int FRAC_OUT = 0,
  parameter int SIGNED   = 0,
  parameter int TAG_W    = 8,
  localparam int RW      = WIDTH / 2 + FRAC_OUT,
  localparam int RMW     = RW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [RW-1:0]    root,
  output logic [RMW-1:0]   rem,
  output logic             err,
  output logic [TAG_W-1:0] out_tag
);

  // Width of the radicand once it is scaled for the fractional bits.
  localparam int XW = WIDTH + 2 * FRAC_OUT;

  // Stage 0 is the capture register. Stage RW drives the outputs.
  logic             vld_q  [0:RW];
  logic [TAG_W-1:0] tag_q  [0:RW];
  logic             err_q  [0:RW];
  logic [RMW-1:0]   rem_q  [0:RW];
  logic [RW-1:0]    root_q [0:RW];
  // Unconsumed radicand bits. They are left-aligned and shift up by 2
  // at each stage.
  logic [XW-1:0]    r_q    [0:RW-1];

  logic [RMW-1:0]   rem_d  [1:RW];
  logic [RW-1:0]    root_d [1:RW];

  logic             neg;
  logic [XW-1:0]    r0_d;

  logic [RMW+1:0]   cat_c;
  logic [RMW:0]     trial_c;
  logic [RMW-1:0]   diff_c;
  logic             ge_c;

  // A negative radicand is flagged and fed through as zero. The result
  // is therefore root=0, rem=0.
  assign neg  = (SIGNED != 0) && x[WIDTH-1];
  assign r0_d = neg ? '0 : (XW'(x) << (2 * FRAC_OUT));

  // Digit recurrence, one root bit per stage. The comparison is done at
  // full width, so it acts as the sign test of the trial subtraction.
  // Both surviving remainders fit in RMW bits, because rem <= 2*root
  // holds after every stage. Only the low RMW bits of the difference
  // are kept.
  always_comb begin
    cat_c   = '0;
    trial_c = '0;
    diff_c  = '0;
    ge_c    = 1'b0;
    for (int i = 1; i <= RW; i++) begin
      rem_d[i]  = '0;
      root_d[i] = '0;
    end
    for (int i = 1; i <= RW; i++) begin
      cat_c     = {rem_q[i-1], r_q[i-1][XW-1 -: 2]};
      trial_c   = {root_q[i-1], 2'b01};
      ge_c      = (cat_c >= {1'b0, trial_c});
      diff_c    = cat_c[RMW-1:0] - trial_c[RMW-1:0];
      rem_d[i]  = ge_c ? diff_c : cat_c[RMW-1:0];
      root_d[i] = {root_q[i-1][RW-2:0], ge_c};
    end
  end

  // Valid chain: the only state that is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= RW; i++) vld_q[i] <= 1'b0;
    end else if (ce) begin
      vld_q[0] <= in_valid;
      for (int i = 1; i <= RW; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Datapath registers. Data in bubbles is don't-care. The output
  // gating below hides it.
  always_ff @(posedge clk) begin
    if (ce) begin
      tag_q[0]  <= in_tag;
      err_q[0]  <= neg;
      rem_q[0]  <= '0;
      root_q[0] <= '0;
      r_q[0]    <= r0_d;
      for (int i = 1; i <= RW; i++) begin
        tag_q[i]  <= tag_q[i-1];
        err_q[i]  <= err_q[i-1];
        rem_q[i]  <= rem_d[i];
        root_q[i] <= root_d[i];
      end
      for (int i = 1; i < RW; i++) begin
        r_q[i] <= {r_q[i-1][XW-3:0], 2'b00};
      end
    end
  end

  // Outputs are zero whenever no result is presented. This also holds
  // while reset is asserted.
  assign out_valid = vld_q[RW];
  assign root      = vld_q[RW] ? root_q[RW] : '0;
  assign rem       = vld_q[RW] ? rem_q[RW]  : '0;
  assign err       = vld_q[RW] ? err_q[RW]  : 1'b0;
  assign out_tag   = vld_q[RW] ? tag_q[RW]  : '0;

endmodule
